// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_t : scan FSM states (idle / blanking guard / digit shown)
//   SEG_BLANK    : segment pattern with every segment off
//   BCD_W        : width of one BCD digit
package seven_seg_scan_ctrl_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd.sv
// Combinational BCD to seven-segment decoder, active-high segments.
//   bcd : BCD digit, codes above 9 decode to all segments off
//   seg : {g,f,e,d,c,b,a}
module BCDto7Segment
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits
// sharing a single BCD decoder. A shadow register accepts new values at
// any time; the display register only takes them at frame start so a frame
// never mixes old and new digits. Each digit slot is REFRESH_DIV clocks:
// BLANK_CYCLES dark guard clocks followed by the lit portion.
//   clk, rst      : clock, synchronous active-high reset
//   en            : scanning enable, 0 holds the display dark and idle
//   load          : capture digits_in / dp_in into the shadow register
//   digits_in     : BCD nibbles, nibble 0 is the least-significant digit
//   dp_in         : decimal point per digit
//   blank_leading : suppress leading zeros (digit 0 is always shown)
//   an            : one-hot active-high anode enables (registered)
//   seg           : {g,f,e,d,c,b,a} active-high (registered)
//   dp            : decimal point of the lit digit (registered)
//   frame_done    : high during the last lit clock of the last digit
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_leading,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic                        frame_done
);

  if (NUM_DIGITS < 2 || BLANK_CYCLES < 1 || REFRESH_DIV <= BLANK_CYCLES) begin : g_param_check
    $error("seven_seg_scan_ctrl: need NUM_DIGITS>=2, BLANK_CYCLES>=1, REFRESH_DIV>BLANK_CYCLES");
  end

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  scan_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             frame_start;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow, disp;
  logic [NUM_DIGITS-1:0]            shadow_dp, disp_dp;

  logic [BCD_W-1:0]       cur_nib;
  logic [6:0]             dec_seg;
  logic [NUM_DIGITS-1:0]  lz_blank;

  logic [NUM_DIGITS-1:0]  an_d;
  logic [6:0]             seg_d;
  logic                   dp_d;
  logic                   frame_done_d;

  // Decoder sees the current digit through both GUARD and SHOW, so its
  // output has settled by the time the anode turns on.
  assign cur_nib = disp[idx];

  BCDto7Segment u_dec (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  // A digit above 0 is a leading zero when it and every higher digit are 0.
  always_comb begin
    logic all_zero_above;
    lz_blank       = '0;
    all_zero_above = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero_above = all_zero_above & (disp[i] == '0);
      lz_blank[i]    = blank_leading & all_zero_above;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_GUARD;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          if (idx == IDX_LAST) begin
            idx_d       = '0;
            frame_start = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      idx_d       = '0;
      frame_start = 1'b0;
    end
  end

  // Outputs are registered from the next state so the anode rises on the
  // same edge that enters SHOW. SHOW is only entered from GUARD of the same
  // digit, so idx and the decoder output already refer to that digit.
  always_comb begin
    an_d         = '0;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    frame_done_d = 1'b0;
    if (state_d == ST_SHOW) begin
      an_d         = AN_ONE << idx;
      frame_done_d = (idx == IDX_LAST) && (cnt_d == SHOW_LAST);
      if (lz_blank[idx]) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
      end else begin
        seg_d = (cur_nib > BCD_W'(9)) ? SEG_BLANK : dec_seg;
        dp_d  = disp_dp[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      an         <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_done_d;
      if (load) begin
        shadow    <= digits_in;
        shadow_dp <= dp_in;
      end
      // A load landing on the frame-start edge goes straight to the display.
      if (frame_start) begin
        disp    <= load ? digits_in : shadow;
        disp_dp <= load ? dp_in : shadow_dp;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, load, blank_leading;
  logic [15:0]  digits_in;
  logic [3:0]   dp_in;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp, frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .load          (load),
    .digits_in     (digits_in),
    .dp_in         (dp_in),
    .blank_leading (blank_leading),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_done    (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: time since scanning started, plus the two buffers.
  bit          m_run = 0;
  int          m_k   = 0;
  logic [15:0] m_shadow = '0, m_disp = '0;
  logic [3:0]  m_sdp = '0, m_ddp = '0;
  logic        m_bl = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, k=%0d)", tag, got, exp, $time, m_k);
    end
  endtask

  function automatic void expect_out(output logic [3:0] e_an, output logic [6:0] e_seg,
                                     output logic e_dp, output logic e_fd);
    int slot, off;
    logic [3:0] nib;
    bit lz;
    e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
    if (!m_run) return;
    slot = (m_k / R) % N;
    off  = m_k % R;
    if (off < B) return;
    e_an = 4'(1 << slot);
    e_fd = (slot == N - 1) && (off == R - 1);
    nib  = m_disp[slot*4 +: 4];
    lz   = 0;
    if (m_bl && slot > 0) begin
      lz = 1;
      for (int j = slot; j < N; j++)
        if (m_disp[j*4 +: 4] != 4'd0) lz = 0;
    end
    if (!lz) begin
      e_dp  = m_ddp[slot];
      e_seg = (nib > 4'd9) ? 7'h00 : seg_tab[nib];
    end
  endfunction

  // One clock: advance the model with the inputs sampled at the edge,
  // then compare every output a little after the edge.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_k = 0;
      m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0;
    end else begin
      if (load) begin
        m_shadow = digits_in;
        m_sdp    = dp_in;
      end
      if (!en) begin
        m_run = 0; m_k = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0;
      end else begin
        m_k++;
      end
      if (m_run && (m_k % (N * R)) == 0) begin
        m_disp = m_shadow;
        m_ddp  = m_sdp;
      end
    end
    m_bl = blank_leading;
    #1;
    expect_out(e_an, e_seg, e_dp, e_fd);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (!(m_run && m_k == target) && guard < 1000) begin
      step();
      guard++;
    end
    check("run_to_reached", 32'(m_run && m_k == target), 32'(1));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; blank_leading = 1'b0;
    digits_in = '0; dp_in = '0;

    // Reset held with en=1: dark throughout.
    repeat (3) begin
      step();
      check("reset_an", 32'(an), 32'(0));
      check("reset_seg", 32'(seg), 32'(0));
      check("reset_fd", 32'(frame_done), 32'(0));
    end

    // Release with a coincident load: bypass straight into the display.
    rst = 1'b0; load = 1'b1; digits_in = 16'h1234;
    step();
    load = 1'b0;
    check("guard0_an", 32'(an), 32'(0));
    step();
    check("guard1_an", 32'(an), 32'(0));
    step();
    check("first_an", 32'(an), 32'(4'b0001));
    check("first_seg", 32'(seg), 32'(7'h66));

    // Scan order.
    run_to(R + B);
    check("d1_an", 32'(an), 32'(4'b0010));
    check("d1_seg", 32'(seg), 32'(7'h4F));
    run_to(2*R + B);
    check("d2_seg", 32'(seg), 32'(7'h5B));
    run_to(3*R + B);
    check("d3_an", 32'(an), 32'(4'b1000));
    check("d3_seg", 32'(seg), 32'(7'h06));
    run_to(4*R - 1);
    check("frame_done_hi", 32'(frame_done), 32'(1));
    step();
    check("frame_done_lo", 32'(frame_done), 32'(0));

    // Atomic update: load mid-frame, old value holds until next frame.
    run_to(5*R + 3);
    load = 1'b1; digits_in = 16'h9999;
    step();
    load = 1'b0;
    run_to(6*R + 4);
    check("atomic_old", 32'(seg), 32'(7'h5B));
    run_to(8*R + B);
    check("atomic_new", 32'(seg), 32'(7'h6F));

    // Leading-zero blanking.
    load = 1'b1; digits_in = 16'h0050; blank_leading = 1'b1;
    step();
    load = 1'b0;
    run_to(12*R + B);
    check("lz_d0", 32'(seg), 32'(7'h3F));
    run_to(13*R + B);
    check("lz_d1", 32'(seg), 32'(7'h6D));
    run_to(14*R + B);
    check("lz_d2", 32'(seg), 32'(7'h00));
    run_to(15*R + B);
    check("lz_d3", 32'(seg), 32'(7'h00));
    blank_leading = 1'b0;
    run_to(19*R + B);
    check("nolz_d3", 32'(seg), 32'(7'h3F));

    // Invalid nibble with decimal point.
    load = 1'b1; digits_in = 16'h12A4; dp_in = 4'b0010;
    step();
    load = 1'b0;
    run_to(20*R + B);
    check("inv_d0_seg", 32'(seg), 32'(7'h66));
    check("inv_d0_dp", 32'(dp), 32'(0));
    run_to(21*R + B);
    check("inv_d1_seg", 32'(seg), 32'(7'h00));
    check("inv_d1_dp", 32'(dp), 32'(1));

    // Disable during SHOW of digit 2, then re-enable.
    run_to(22*R + B + 1);
    en = 1'b0;
    step();
    check("dis_an", 32'(an), 32'(0));
    repeat (3) step();
    en = 1'b1;
    step();
    step();
    step();
    check("reen_an", 32'(an), 32'(4'b0001));
    check("reen_seg", 32'(seg), 32'(7'h66));

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom % 500) == 0;
      en   = ($urandom % 150) != 0;
      load = ($urandom % 20) == 0;
      if (($urandom % 50) == 0) blank_leading = ~blank_leading;
      for (int d = 0; d < N; d++) begin
        int r;
        r = $urandom % 8;
        if (r < 3)       digits_in[d*4 +: 4] = 4'd0;
        else if (r == 3) digits_in[d*4 +: 4] = 4'($urandom_range(10, 15));
        else             digits_in[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      dp_in = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller that shares one `BCDto7Segment` decoder across `NUM_DIGITS` common-anode digit positions. It holds a double-buffered BCD word and steps through the digits one slot at a time. For each slot it drives the decoder's `bcd` input, enables exactly one anode, and inserts a blanking guard between digits to prevent ghosting. It sits between the number-producing logic (counters, ALU result registers) and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: digit positions scanned; ≥2.
- `REFRESH_DIV`, 1000: clocks per digit slot; > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 2: guard clocks at slot start with all anodes off; ≥1.
- `clk` in 1: single clock. Reset is synchronous, active-high.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scanning enable; 0 forces idle/dark.
- `load` in 1: capture `digits_in`/`dp_in` into the shadow register.
- `digits_in` in 4*NUM_DIGITS: BCD nibbles; nibble 0 is the least-significant digit.
- `dp_in` in NUM_DIGITS: decimal-point bit per digit.
- `blank_leading` in 1: suppress leading zeros.
- `an` out NUM_DIGITS: one-hot active-high anode enables.
- `seg` out 7: {g,f,e,d,c,b,a}, active-high.
- `dp` out 1: decimal point for the active digit.
- `frame_done` out 1: one-cycle pulse when the last digit slot ends.

## Operation
- **Buffers.**
  - `load` writes the shadow register.
  - The display register copies the shadow only at frame start, i.e. on entry to GUARD of digit 0, so a frame never shows mixed values.
  - If `load` and a frame start coincide, the display register takes `digits_in`/`dp_in` directly (bypass).
- **FSM states: IDLE, GUARD, SHOW.**
  - IDLE → GUARD (index 0) when `en`=1.
  - GUARD → SHOW after `BLANK_CYCLES` clocks.
  - SHOW → GUARD (next index) after `REFRESH_DIV-BLANK_CYCLES` clocks.
  - Any state → IDLE when `en`=0; index resets to 0.
- **Index.** Counts 0 → `NUM_DIGITS-1`, then wraps to 0. The wrap asserts `frame_done` in the last SHOW clock of digit `NUM_DIGITS-1`.
- **Decoder sharing.** The decoder `bcd` input is driven by the display nibble at the current index throughout GUARD and SHOW. GUARD gives the decoder output time to settle before the anode turns on.
- **Segment output.** In SHOW, the registered `seg` equals the decoder output, with these overrides:
  - a nibble >9 forces `seg`=0 (blank);
  - a blanked leading zero forces `seg`=0 and `dp`=0.
- **Leading-zero rule.** With `blank_leading`=1, a digit at index i>0 is blanked iff it and every digit above it are 0. Digit 0 is never blanked.
- **Outputs outside SHOW.** `an`=0, `seg`=0, `dp`=0.
- **Decoder codes.** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).

## Timing
- All outputs are registered.
- **Reset values.** `an`=0, `seg`=0, `dp`=0, `frame_done`=0; state IDLE, index 0, slot counter 0, shadow=0, display=0.
- **Start-up.** `en` sampled 1 at edge t enters GUARD. The first anode asserts at edge t+`BLANK_CYCLES`.
- **Slot and frame length.** Each slot is exactly `REFRESH_DIV` clocks, so a frame is `NUM_DIGITS*REFRESH_DIV` clocks.
- **Load latency.** A `load` becomes visible at the next frame start; worst case is one frame plus `BLANK_CYCLES`.
- **`en` dropped mid-slot.** `an`=0 on the next edge. The shadow is kept; re-enabling restarts from digit 0.
- **`rst` mid-frame.** All state returns to reset values on the next edge, regardless of `en`/`load`.
- **Anode exclusivity.** `an` is never multi-hot. At least `BLANK_CYCLES` all-zero clocks separate consecutive anodes.

## Structure
- **Shared package:**
  - FSM state enum (IDLE/GUARD/SHOW);
  - `SEG_BLANK`=7'h00;
  - BCD width constant 4.
- **Sub-module:** one instance of `BCDto7Segment`. All scan logic stays in this module.
- **Parameter guard:** an elaboration-time assertion on the parameter constraints.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
1. **Reset.** `rst`=1 for 3 clocks with `en`=1 → `an`=0, `seg`=0, `frame_done`=0 throughout. After release, the first `an`=0001 appears exactly 2 clocks later.
2. **Scan order.** `load` 16'h1234, `en`=1 → `an`/`seg` sequence 0001/4F? No: the least-significant nibble is 4, so the sequence is 0001/66, 0010/4F, 0100/5B, 1000/06. Each anode is on for 6 clocks, separated by 2 dark clocks. `frame_done` pulses every 32 clocks.
3. **Atomic update.** `load` 16'h9999 mid-frame while 16'h1234 is showing → the rest of the frame still shows 1234. The next frame shows 6F on all digits.
4. **Leading-zero blanking.** `load` 16'h0050, `blank_leading`=1 → digits 3 and 2 show `seg`=0, digit 1 shows 6D, digit 0 shows 3F. With `blank_leading`=0, digits 3 and 2 show 3F.
5. **Invalid nibble and decimal point.** Nibble 4'hA at index 1 with `dp_in`=0010 → digit 1 shows `seg`=0 and `dp`=1. Other digits decode normally with `dp`=0.
6. **Disable mid-slot.** Drop `en` during SHOW of digit 2 → `an`=0 on the next edge. On re-enable, scanning restarts at digit 0 with the shadow contents intact.
